// File: rtl/msk_rcon_sched.sv
// msk_rcon_sched: AES round-constant scheduler emitting a d-share masked rcon per round.
// Ports: clk, nrst (async active-low), start/abort control, busy,
//        out_valid/out_ready handshake, out_rcon (8*d shares), out_round, out_last.
// Optional: MSK_RCON_SCHED_INVERSE_EN adds input inverse to run the schedule backwards.
module msk_rcon_sched #(
  parameter int d       = 2,
  parameter int NROUNDS = 10
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic           start,
  input  logic           abort,
`ifdef MSK_RCON_SCHED_INVERSE_EN
  input  logic           inverse,
`endif
  output logic           busy,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [8*d-1:0] out_rcon,
  output logic [3:0]     out_round,
  output logic           out_last
);
  function automatic logic [7:0] fwd_at(input int n);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 1; k < n; k++) r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
    return r;
  endfunction
  localparam logic [7:0] RC_LAST = fwd_at(NROUNDS);
  typedef enum logic {IDLE, RUN} state_t;
  state_t     state, state_nx;
  logic [7:0] rcon, rcon_nx;
  logic [3:0] cnt, cnt_nx;
  logic       inv, inv_nx, inv_in, fin, run;
`ifdef MSK_RCON_SCHED_INVERSE_EN
  assign inv_in = inverse;
`else
  assign inv_in = 1'b0;
`endif
  assign run = state == RUN;
  assign fin = cnt == 4'(NROUNDS - 1);
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state <= IDLE;
      rcon  <= '0;
      cnt   <= '0;
      inv   <= 1'b0;
    end else begin
      state <= state_nx;
      rcon  <= rcon_nx;
      cnt   <= cnt_nx;
      inv   <= inv_nx;
    end
  // abort wins over start and over a same-cycle transfer; the final transfer
  // always lands in IDLE so a restart needs at least one IDLE cycle
  always_comb begin
    state_nx = state;
    rcon_nx  = rcon;
    cnt_nx   = cnt;
    inv_nx   = inv;
    if (abort) begin
      state_nx = IDLE;
      rcon_nx  = '0;
      cnt_nx   = '0;
    end else if (!run) begin
      if (start) begin
        state_nx = RUN;
        rcon_nx  = inv_in ? RC_LAST : 8'h01;
        cnt_nx   = '0;
        inv_nx   = inv_in;
      end
    end else if (out_ready) begin
      state_nx = fin ? IDLE : RUN;
      cnt_nx   = fin ? 4'd0 : cnt + 4'd1;
      rcon_nx  = fin ? 8'h00 :
                 inv ? (rcon[0] ? ((rcon ^ 8'h1B) >> 1) | 8'h80 : rcon >> 1) :
                       {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1B : 8'h00);
    end
  end
  assign busy      = run;
  assign out_valid = run;
  assign out_round = run ? cnt : 4'd0;
  assign out_last  = run & fin;
  // share 0 carries the public bit; the remaining shares are constant zero
  for (genvar i = 0; i < 8; i++) begin : g_enc
    assign out_rcon[i*d +: d] = {{(d-1){1'b0}}, run & rcon[i]};
  end
endmodule

// File: tb/tb_msk_rcon_sched.sv
// tb_msk_rcon_sched: randomized and directed check of msk_rcon_sched against a sequence model.
module tb_msk_rcon_sched;
  localparam int N = 10;
  logic clk = 1'b0, nrst = 1'b0, start = 1'b0, abort = 1'b0, out_ready = 1'b0, inverse = 1'b0;
  logic busy, out_valid, out_last, busy3, valid3, last3;
  logic [15:0] out_rcon;
  logic [23:0] out_rcon3;
  logic [3:0] out_round, round3;
  int checks = 0, errors = 0;
  logic [7:0] fwd [N];
  logic m_run = 1'b0, m_inv = 1'b0;
  int m_idx = 0;

  always #5 clk = ~clk;

  msk_rcon_sched #(.d(2), .NROUNDS(N)) u2 (
    .clk(clk), .nrst(nrst), .start(start), .abort(abort),
`ifdef MSK_RCON_SCHED_INVERSE_EN
    .inverse(inverse),
`endif
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_rcon(out_rcon), .out_round(out_round), .out_last(out_last));

  msk_rcon_sched #(.d(3), .NROUNDS(N)) u3 (
    .clk(clk), .nrst(nrst), .start(start), .abort(abort),
`ifdef MSK_RCON_SCHED_INVERSE_EN
    .inverse(inverse),
`endif
    .busy(busy3), .out_valid(valid3), .out_ready(out_ready),
    .out_rcon(out_rcon3), .out_round(round3), .out_last(last3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] enc(input logic [7:0] v, input int dd);
    logic [23:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*dd] = v[i];
    return r;
  endfunction

  function automatic logic [7:0] exp_rcon();
    if (!m_run) return 8'h00;
    return m_inv ? fwd[N-1-m_idx] : fwd[m_idx];
  endfunction

  task automatic check_outputs();
    chk("busy", busy, m_run);
    chk("valid", out_valid, m_run);
    chk("round", out_round, m_run ? m_idx : 0);
    chk("last", out_last, m_run && m_idx == N-1);
    chk("rcon_d2", out_rcon, enc(exp_rcon(), 2));
    chk("rcon_d3", out_rcon3, enc(exp_rcon(), 3));
  endtask

  task automatic step(input logic st, input logic ab, input logic rd, input logic iv);
    @(negedge clk);
    start = st; abort = ab; out_ready = rd; inverse = iv;
    #1 check_outputs();
    @(posedge clk);
    if (ab) m_run = 1'b0;
    else if (!m_run) begin
      if (st) begin
        m_run = 1'b1;
        m_idx = 0;
`ifdef MSK_RCON_SCHED_INVERSE_EN
        m_inv = iv;
`else
        m_inv = 1'b0;
`endif
      end
    end else if (rd) begin
      if (m_idx == N-1) m_run = 1'b0;
      else m_idx++;
    end
  endtask

  task automatic run_to(input int k);
    for (int i = 0; i < 2*N && m_run && m_idx != k; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("reach_round", m_idx, k);
  endtask

  initial begin
    fwd[0] = 8'h01;
    for (int k = 1; k < N; k++) begin
      int v;
      v = int'(fwd[k-1]) * 2;
      if (v >= 256) v = v ^ 'h11B;
      fwd[k] = 8'(v);
    end
    chk("fwd_last_const", fwd[N-1], 8'h36);
    #12;
    check_outputs();
    @(negedge clk) nrst = 1'b1;
    // full forward run with constant ready, then one idle cycle
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < N; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    // stall at round 4
    step(1'b1, 1'b0, 1'b1, 1'b0);
    run_to(4);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("stall_rcon", out_rcon, enc(8'h10, 2));
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("resume_rcon", exp_rcon(), 8'h20);
    run_to(N-1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    // abort at round 6 with start and ready high
    step(1'b1, 1'b0, 1'b1, 1'b0);
    run_to(6);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    // async reset at round 8, also d=3 encoding of 0x1B
    step(1'b1, 1'b0, 1'b1, 1'b0);
    run_to(8);
    @(negedge clk);
    #1 chk("d3_1b", out_rcon3, 24'h001209);
    #2 nrst = 1'b0;
    m_run = 1'b0;
    #1 check_outputs();
    @(negedge clk) nrst = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b0);
`ifdef MSK_RCON_SCHED_INVERSE_EN
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("inv_first", exp_rcon(), 8'h36);
    for (int i = 0; i < N; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
`endif
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0,
           $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/msk_rcon_sched.md
MSK_RCON_SCHED -- requirements
Module: msk_rcon_sched

Interface
REQ-001 SHALL have parameter d, default 2, meaning number of shares per bit (d >= 2).
REQ-002 SHALL have parameter NROUNDS, default 10, meaning number of round constants issued per run (1..10).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  run request; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  synchronous run cancel.
REQ-007 SHALL have port busy  output  1  high in RUN.
REQ-008 SHALL have port out_valid  output  1  sharing valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts.
REQ-010 SHALL have port out_rcon  output  8*d  masked rcon, bit i at [i*d +: d] = {(d-1) zeros, rcon[i]}.
REQ-011 SHALL have port out_round  output  4  index of issued constant, 0-based.
REQ-012 SHALL have port out_last  output  1  high with the final constant of the run.

Function
REQ-013 SHALL implement states IDLE and RUN only.
REQ-014 SHALL move IDLE->RUN on start=1 and abort=0; rcon register loads 0x01, round counter loads 0.
REQ-015 SHALL assert out_valid in every RUN cycle and never in IDLE.
REQ-016 SHALL count a transfer only when out_valid & out_ready; no transfer leaves all state unchanged (outputs stable under stall).
REQ-017 SHALL on each transfer update rcon = {rcon[6:0],0} xor (rcon[7] ? 0x1B : 0x00) and increment the counter.
REQ-018 SHALL return RUN->IDLE on the transfer with counter = NROUNDS-1; out_last = (counter == NROUNDS-1) in RUN.
REQ-019 SHALL issue 01,02,04,08,10,20,40,80,1B,36 for NROUNDS=10; no wrap-around beyond NROUNDS.
REQ-020 SHALL ignore start while in RUN, including in the final-transfer cycle (no back-to-back restart; one IDLE cycle minimum).
REQ-021 SHALL force IDLE on abort=1 in any state, with priority over start and over a same-cycle transfer (that transfer is still counted by the consumer; scheduler discards the run).
REQ-022 SHALL drive out_rcon, out_round, out_last to all-zero in IDLE.
REQ-023 SHALL have zero latency: out_rcon is a combinational share-encoding of the rcon register, no extra pipeline stage.
REQ-024 SHALL keep shares 1..d-1 of every bit constant zero (public value, no randomness consumed).

Reset
REQ-025 SHALL on nrst=0, asynchronously, enter IDLE, clear rcon and counter; busy, out_valid, out_last, out_round, out_rcon all 0.
REQ-026 SHALL on reset mid-RUN discard the run; first cycle after release is IDLE.

Configuration
REQ-027 SHALL compile an input port inverse (1 bit, sampled with start) only when MSK_RCON_SCHED_INVERSE_EN is defined.
REQ-028 SHALL with the macro and inverse=1 load rcon with the NROUNDS-th forward constant (0x36 for 10) and update per transfer by inverse xtime: rcon[0] ? ((rcon xor 0x1B)>>1) | 0x80 : rcon>>1; out_round still counts up from 0.
REQ-029 SHALL with the macro and inverse=0, or without the macro, behave forward-only per REQ-017; without the macro no inverse port exists.

Verification
REQ-030 SHALL cover: reset, start pulse, out_ready=1 constant -> 10 valid cycles, rcon 01..36, out_last only with 0x36, busy drops next cycle.
REQ-031 SHALL cover: out_ready low 3 cycles at round 4 -> out_rcon holds 0x10 sharing, out_round 4, then resumes 0x20.
REQ-032 SHALL cover: abort at round 6 with out_ready=1 and start=1 -> IDLE next cycle, outputs zero, start ignored.
REQ-033 SHALL cover: nrst asserted mid-run at round 8 -> outputs zero immediately (same cycle, no clock edge).
REQ-034 SHALL cover: d=3, round 8 -> out_rcon bit 0 field 3'b001, bit 1 field 3'b001, bit 3 field 3'b001, bit 4 field 3'b001, all others 3'b000 (0x1B).
REQ-035 SHALL cover with MSK_RCON_SCHED_INVERSE_EN: inverse=1 start -> 36,1B,80,40,20,10,08,04,02,01, out_last with 0x01.
